// File: rtl/record_pkg.sv
// Shared widths, record layout and FSM state type for the record serializer.
// The optional checksum byte is enabled by RECORD_SER_CHECKSUM_EN (see record_serializer).
package record_pkg;

    localparam int W_WIDTH = 32;
    localparam int X_WIDTH = 32;
    localparam int Y_WIDTH = 8;
    localparam int Z_WIDTH = 1;

    localparam int REC_W  = W_WIDTH + X_WIDTH + Y_WIDTH + Z_WIDTH;
    localparam int NBYTES = (REC_W + 7) / 8;
    localparam int PAD    = 8 * NBYTES - REC_W;
    // One extra code is reserved so the checksum byte can have its own index.
    localparam int IDX_W  = $clog2(NBYTES + 1);

    typedef struct packed {
        logic [W_WIDTH-1:0] w;
        logic [X_WIDTH-1:0] x;
        logic [Y_WIDTH-1:0] y;
        logic [Z_WIDTH-1:0] z;
    } rec_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    function automatic logic [7:0] top_byte(input logic [8*NBYTES-1:0] v);
        return v[8*NBYTES-1 -: 8];
    endfunction

endpackage

// File: rtl/record_ser_csum.sv
// Byte-wise XOR accumulator; acc_next exposes the value the register takes next edge.
module record_ser_csum
    import record_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] acc_next
);

    logic [7:0] acc_r;
    logic [7:0] acc_s;

    // Next accumulator value: clear wins over accumulate.
    always_comb begin
        acc_s = acc_r;
        if (clear) begin
            acc_s = 8'h00;
        end else if (en) begin
            acc_s = acc_r ^ din;
        end else begin
            acc_s = acc_r;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= 8'h00;
        end else begin
            acc_r <= acc_s;
        end
    end

    assign acc_next = acc_s;

endmodule

// File: rtl/record_serializer.sv
// Serializes one packed {w,x,y,z} record per handshake into an MSB-first byte stream.
// Define RECORD_SER_CHECKSUM_EN to append an XOR checksum byte after each record.
module record_serializer
    import record_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REC_W-1:0] in_rec,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    localparam int SR_W = 8 * NBYTES;
    localparam logic [IDX_W-1:0] IDX_ONE       = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(NBYTES - 1);
`ifdef RECORD_SER_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(NBYTES);
`else
    localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(NBYTES - 1);
`endif

    ser_state_t        state_r, state_s;
    logic [IDX_W-1:0]  idx_r, idx_s;
    logic [SR_W-1:0]   shift_r, shift_s;
    logic [7:0]        data_r, data_s;
    logic              valid_r, valid_s;
    logic              last_r, last_s;
    logic [SR_W-1:0]   padded_s;
    logic              in_ready_s;
    logic              in_fire_s;
    logic              out_fire_s;

    assign padded_s   = {{PAD{1'b0}}, in_rec};
    // A new record may be taken while the final byte of the current one leaves.
    assign in_ready_s = rst_n && ((state_r == IDLE) ||
                                  ((state_r == SEND) && out_ready && last_r));
    assign in_fire_s  = in_valid && in_ready_s;
    assign out_fire_s = valid_r && out_ready;

`ifdef RECORD_SER_CHECKSUM_EN
    logic [7:0] csum_next_s;
    logic       csum_en_s;

    assign csum_en_s = out_fire_s && (idx_r <= LAST_DATA_IDX);

    record_ser_csum u_csum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (in_fire_s),
        .en       (csum_en_s),
        .din      (data_r),
        .acc_next (csum_next_s)
    );
`endif

    // Next-state and next-output computation; everything holds by default.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        shift_s = shift_r;
        data_s  = data_r;
        valid_s = valid_r;
        last_s  = last_r;
        case (state_r)
            IDLE: begin
                if (in_fire_s) begin
                    state_s = SEND;
                    idx_s   = '0;
                    shift_s = padded_s;
                    data_s  = top_byte(padded_s);
                    valid_s = 1'b1;
                    last_s  = (LAST_IDX == '0);
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (out_fire_s) begin
                    if (idx_r == LAST_IDX) begin
                        if (in_fire_s) begin
                            state_s = SEND;
                            idx_s   = '0;
                            shift_s = padded_s;
                            data_s  = top_byte(padded_s);
                            valid_s = 1'b1;
                            last_s  = (LAST_IDX == '0);
                        end else begin
                            state_s = IDLE;
                            valid_s = 1'b0;
                            last_s  = 1'b0;
                        end
                    end else begin
                        idx_s   = idx_r + IDX_ONE;
                        shift_s = {shift_r[SR_W-9:0], 8'h00};
                        data_s  = top_byte(shift_s);
`ifdef RECORD_SER_CHECKSUM_EN
                        if (idx_r == LAST_DATA_IDX) begin
                            data_s = csum_next_s;
                        end else begin
                            data_s = top_byte(shift_s);
                        end
`endif
                        last_s  = (idx_s == LAST_IDX);
                    end
                end else begin
                    state_s = SEND;
                end
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
                last_s  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= '0;
            shift_r <= '0;
            data_r  <= 8'h00;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            last_r  <= last_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = data_r;
    assign out_valid = valid_r;
    assign out_last  = last_r;

endmodule

// File: tb/tb_record_serializer.sv
// Directed self-checking bench for record_serializer (optionally with RECORD_SER_CHECKSUM_EN).
module tb_record_serializer;
    import record_pkg::*;

`ifdef RECORD_SER_CHECKSUM_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [REC_W-1:0] in_rec;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_tab [0:3][0:10];
    rec_t       rec_tab [0:3];

    always #5 clk = ~clk;

    record_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_rec    (in_rec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_in();
        in_rec = REC_W'({$urandom(), $urandom(), $urandom()});
    endtask

    task automatic accept(input int id);
        int n;
        in_rec   = rec_tab[id];
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait rec%0d in_ready=%b expected 1", id, in_ready);
        end
        step();
        in_valid = 1'b0;
        scramble_in();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_byte_latency rec%0d out_valid=%b expected 1", id, out_valid);
        end
    endtask

    task automatic drain(input int id, input int stall_at, input int stall_len,
                         input int stop_at, input int next_id);
        for (int k = 0; k < stop_at; k++) begin
            if (k == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== exp_tab[id][k] || out_last !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_hold rec%0d k=%0d got v=%b d=%h l=%b expected v=1 d=%h l=0",
                                 id, k, out_valid, out_data, out_last, exp_tab[id][k]);
                    end
                end
                out_ready = 1'b1;
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_tab[id][k]) begin
                errors++;
                $display("FAIL byte_data rec%0d k=%0d got v=%b d=%h expected v=1 d=%h",
                         id, k, out_valid, out_data, exp_tab[id][k]);
            end
            checks++;
            if (out_last !== (k == NB - 1)) begin
                errors++;
                $display("FAIL byte_last rec%0d k=%0d got %b expected %b",
                         id, k, out_last, (k == NB - 1));
            end
            if (k == NB - 1 && next_id >= 0) begin
                in_rec   = rec_tab[next_id];
                in_valid = 1'b1;
                #1;
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready rec%0d in_ready=%b expected 1", id, in_ready);
                end
            end
            step();
            if (k == NB - 1 && next_id >= 0) begin
                in_valid = 1'b0;
                scramble_in();
            end
        end
        if (stop_at == NB && next_id < 0) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL record_end rec%0d got v=%b rdy=%b expected v=0 rdy=1",
                         id, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b rdy=%b d=%h l=%b expected 0 0 00 0",
                     out_valid, in_ready, out_data, out_last);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
                errors++;
                $display("FAIL idle cyc=%0d got v=%b rdy=%b d=%h expected 0 1 00",
                         i, out_valid, in_ready, out_data);
            end
            step();
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        accept(0);
        drain(0, -1, 0, NB, -1);
    endtask

    task automatic test_all_ones();
        accept(1);
        drain(1, -1, 0, NB, -1);
    endtask

    task automatic test_backpressure();
        accept(1);
        drain(1, 4, 3, NB, -1);
    endtask

    task automatic test_back_to_back();
        accept(2);
        drain(2, -1, 0, NB, 3);
        drain(3, -1, 0, NB, -1);
    endtask

    task automatic test_reset_mid();
        accept(1);
        drain(1, -1, 0, 6, -1);
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_drop got v=%b rdy=%b expected 0 0", out_valid, in_ready);
        end
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold got v=%b rdy=%b expected 0 0", out_valid, in_ready);
        end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_release got v=%b d=%h expected 0 00", out_valid, out_data);
        end
        accept(0);
        drain(0, -1, 0, NB, -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_rec    = '0;

        rec_tab[0] = '{32'd1, 32'd1, 8'd1, 1'b1};
        rec_tab[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'hFF, 1'b1};
        rec_tab[2] = '{32'd0, 32'd0, 8'd0, 1'b0};
        rec_tab[3] = '{32'd2, 32'd2, 8'd3, 1'b1};
        for (int r = 0; r < 4; r++) begin
            for (int b = 0; b < 11; b++) begin
                exp_tab[r][b] = 8'h00;
            end
        end
        exp_tab[0][4] = 8'h02; exp_tab[0][8] = 8'h02; exp_tab[0][9] = 8'h03; exp_tab[0][10] = 8'h03;
        exp_tab[1][0] = 8'h01;
        for (int b = 1; b < 10; b++) begin
            exp_tab[1][b] = 8'hFF;
        end
        exp_tab[1][10] = 8'hFE;
        exp_tab[3][4] = 8'h04; exp_tab[3][8] = 8'h04; exp_tab[3][9] = 8'h07; exp_tab[3][10] = 8'h07;

        test_reset();
        test_idle();
        test_basic();
        test_all_ones();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/record_serializer.md
Name: record_serializer

Overview:
- Downstream consumer of the packed record {w, x, y, z}, widths 32/32/8/1, 73 bits total, w in the MSBs.
- Accepts one record per valid/ready handshake and emits it as a byte stream, MSB first, with a last-byte flag.
- Sits between the record-packing stage and any byte-wide link or log sink.

Parameters:
- W_WIDTH, 32, width of field w.
- X_WIDTH, 32, width of field x.
- Y_WIDTH, 8, width of field y.
- Z_WIDTH, 1, width of field z.
- Derived localparams:
  - REC_W = sum of the four field widths (73).
  - NBYTES = ceil(REC_W/8) (10).
  - PAD = 8*NBYTES - REC_W (7).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_rec  in  REC_W  packed record {w, x, y, z}.
- in_valid  in  1  record present.
- in_ready  out  1  record accepted when in_valid && in_ready.
- out_data  out  8  serialized byte.
- out_valid  out  1  byte present.
- out_ready  in  1  byte consumed when out_valid && out_ready.
- out_last  out  1  marks the final byte of a record.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, byte index=0, shift register=0.
  - out_valid=0, out_data=8'h00, out_last=0.
  - in_ready is forced 0 while rst_n=0.
- States:
  - IDLE: in_ready=1. On accept, capture {PAD zeros, in_rec} into an 8*NBYTES shift register, set idx=0, go to SEND.
  - SEND: out_valid=1, out_data = current top byte, out_last=(idx==NBYTES-1).
  - On an out handshake with idx<NBYTES-1: shift left 8 and increment idx.
  - On an out handshake at the last byte: go to IDLE, or reload directly if a new record is accepted in the same cycle.
- in_ready = (state==IDLE) || (state==SEND && out_ready && out_last). Back-to-back records therefore have zero bubble cycles.
- Latency: a record accepted at edge N drives its first byte with out_valid=1 during cycle N+1 (registered outputs).
- Backpressure: while out_valid && !out_ready, out_data, out_last and idx hold stable.
- Byte order: byte k = padded[8*NBYTES-1-8k -: 8]. Pad bits are 0 and occupy the MSBs of byte 0.
- in_rec is sampled only at handshake; later changes to in_rec have no effect on the record in flight.
- X/Z bits on in_rec propagate unchanged into the bytes; no resolution is performed.
- Reset mid-record: the in-flight record is discarded and out_valid drops immediately. After release, the next accepted record starts at byte 0.
- In IDLE, out_data holds its last value, and out_valid=0 is the only qualifier.

Optional Feature:
- Macro: RECORD_SER_CHECKSUM_EN.
- Defined:
  - After the NBYTES data bytes, one extra byte is emitted: the XOR of all NBYTES data bytes.
  - out_last moves to the checksum byte.
  - in_ready back-to-back acceptance moves to the checksum handshake.
  - The checksum accumulator resets to 0 on each record load.
- Undefined:
  - No checksum byte; exactly NBYTES bytes per record.
  - No accumulator logic exists.

Decomposition:
- Package record_pkg holds:
  - the field-width localparams, REC_W and NBYTES;
  - typedef struct packed rec_t {w, x, y, z};
  - the state enum ser_state_t {IDLE, SEND}.
- One sub-module, record_ser_csum: byte-XOR accumulator with clear and enable, instantiated only under RECORD_SER_CHECKSUM_EN.

Test Plan:
- Record w=1, x=1, y=1, z=1, out_ready=1 -> bytes 00 00 00 00 02 00 00 00 02 03, out_last on byte 10, first byte the cycle after accept. With checksum enabled, an 11th byte 03 carries out_last.
- Record all ones (w=x=-1, y=8'hFF, z=1) -> bytes 01 then FF x9. Checksum byte FE when enabled.
- Same all-ones record, out_ready low for 3 cycles at byte index 4 -> out_data=FF, out_valid=1 and out_last=0 held stable; stream resumes with no lost or duplicated byte.
- Two records presented back-to-back (all-zero, then w=2, x=2, y=3, z=1) -> second accepted on the last-byte handshake of the first; the first byte of the second follows with no idle cycle.
- rst_n pulsed low while byte 6 is pending -> out_valid=0 and in_ready=0 during reset. After release the next record streams from byte 0, and no leftover bytes of the aborted record appear.
- in_valid=0 after reset for 5 cycles -> out_valid stays 0, in_ready=1, out_data=00.
